pw_usb_packet_parser: RTL and testbench
=======================================

PW_USB_PACKET_PARSER -- requirements
Module: pw_usb_packet_parser

Interface
REQ-001 The block SHALL have fe_clk, input, 1 bit: the front-end capture clock; all logic is clocked on its rising edge.
REQ-002 The block SHALL have reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have I_data, input, 8 bits: a received byte from the capture pattern-match path.
REQ-004 The block SHALL have I_data_wr, input, 1 bit: a one-cycle strobe that qualifies I_data.
REQ-005 The block SHALL have I_rxactive, input, 1 bit: high for the duration of a received packet.
REQ-006 The block SHALL have I_enable, input, 1 bit: when low, the parser is held in IDLE.
REQ-007 The block SHALL have O_pid, output, 4 bits: the PID of the current or last packet.
REQ-008 The block SHALL have O_pid_valid, output, 1 bit: a one-cycle pulse when a PID is accepted.
REQ-009 The block SHALL have O_pid_err, output, 1 bit: a one-cycle pulse when the PID check fails.
REQ-010 The block SHALL have O_token_addr, output, 7 bits, and O_token_endp, output, 4 bits: decoded token fields.
REQ-011 The block SHALL have O_token_valid, output, 1 bit: a one-cycle pulse when the token fields are updated.
REQ-012 The block SHALL have O_frame_num, output, 11 bits, and O_sof, output, 1 bit: the SOF frame number and its one-cycle update pulse.
REQ-013 The block SHALL have O_byte_count, output, 11 bits: the byte count of the current packet, PID included.
REQ-014 The block SHALL have O_pkt_done, output, 1 bit: a one-cycle end-of-packet pulse.
REQ-015 The block SHALL have O_crc_err, output, 1 bit: valid while O_pkt_done is high.
REQ-016 The block SHALL have O_pkt_count, output, 16 bits: a running count of completed packets.

Function
REQ-017 The FSM SHALL have the states IDLE, PID, BODY, DROP and DONE.
REQ-018 FSM transitions SHALL be:
- IDLE->PID on a rising edge of I_rxactive while I_enable=1.
- PID->BODY on I_data_wr when I_data[7:4] == ~I_data[3:0].
- PID->DROP on I_data_wr otherwise.
- BODY->DONE and DROP->IDLE when I_rxactive falls.
- DONE->IDLE unconditionally after one cycle.
REQ-019 On PID accept, O_pid SHALL take I_data[3:0] and O_pid_valid SHALL pulse on the next cycle; on PID failure, O_pid_err SHALL pulse on the next cycle and O_pid SHALL hold its previous value.
REQ-020 O_byte_count SHALL clear on entry to PID, increment on each I_data_wr in PID or BODY, and saturate at 2047.
REQ-021 For token PIDs (O_pid[1:0]=01), body byte 1 and byte 2 SHALL be captured and the fields formed as:
- O_token_addr = byte1[6:0].
- O_token_endp = {byte2[2:0], byte1[7]}.
- O_token_valid pulses one cycle after byte 2.
- Bytes beyond 2 are ignored.
REQ-022 For SOF (O_pid=4'b0101), O_frame_num SHALL be {byte2[2:0], byte1}, O_sof SHALL pulse one cycle after byte 2, and O_token_valid SHALL NOT pulse.
REQ-023 A token or SOF ending with fewer than 2 body bytes SHALL produce no O_token_valid or O_sof pulse and SHALL assert O_crc_err at O_pkt_done.
REQ-024 O_pkt_done SHALL pulse in the DONE state only, one cycle after the falling edge of I_rxactive; DROP produces no O_pkt_done.
REQ-025 O_pkt_count SHALL increment on each O_pkt_done and wrap 0xFFFF->0x0000.
REQ-026 I_data_wr coincident with the falling edge of I_rxactive SHALL be processed as the final byte before DONE.
REQ-027 I_enable falling mid-packet SHALL force IDLE on the next cycle with no O_pkt_done; the outputs hold.
REQ-028 I_data_wr while in IDLE or DONE SHALL be ignored.

Reset
REQ-029 Asserting reset_i SHALL immediately force IDLE and clear all outputs and counters to 0, including mid-packet.
REQ-030 After reset_i deasserts, a packet already in progress (I_rxactive already high) SHALL be ignored until I_rxactive next rises.

Configuration
REQ-031 With PW_CRC16_CHECK_EN defined, data packets (O_pid[1:0]=11) SHALL be checked with a reflected CRC16:
- Polynomial 0xA001, initial value 0xFFFF, updated on each body byte.
- O_crc_err = (register != 16'hB001) at O_pkt_done.
- Data packets with fewer than 2 body bytes SHALL flag O_crc_err.
REQ-032 Without PW_CRC16_CHECK_EN, no CRC logic SHALL be synthesised, and O_crc_err SHALL be driven only by REQ-023.

Verification
REQ-033 The bench SHALL cover SOF 0xA5,0x3A,0x05 -> O_sof pulse, O_frame_num=0x53A, O_byte_count=3, O_pkt_done with O_crc_err=0, O_pkt_count=1.
REQ-034 The bench SHALL cover IN 0x69,0x82,0x01 -> O_token_valid pulse, O_token_addr=0x02, O_token_endp=0x3, O_pid=0x9.
REQ-035 The bench SHALL cover PID byte 0x00 -> O_pid_err pulse, no O_pkt_done, O_pkt_count unchanged.
REQ-036 The bench SHALL cover DATA0 0xC3,0x00,0x00 -> O_crc_err=0; 0xC3,0x00,0x01 -> O_crc_err=1 with the macro defined, 0 without it.
REQ-037 The bench SHALL cover reset_i pulsed after byte 2 of a 10-byte packet -> all outputs 0, no O_pkt_done, and the next packet parses normally.
REQ-038 The bench SHALL cover 65536 SOF packets -> O_pkt_count wraps to 0, and a packet with 2100 bytes -> O_byte_count=2047.

Source files
------------

// File: rtl/pw_usb_packet_parser_if.sv
// Byte-stream inputs and decoded-field outputs of the USB packet parser.
// master drives the byte stream, slave is the parser.
interface pw_usb_packet_parser_if;
  logic [7:0]  I_data;
  logic        I_data_wr;
  logic        I_rxactive;
  logic        I_enable;
  logic [3:0]  O_pid;
  logic        O_pid_valid;
  logic        O_pid_err;
  logic [6:0]  O_token_addr;
  logic [3:0]  O_token_endp;
  logic        O_token_valid;
  logic [10:0] O_frame_num;
  logic        O_sof;
  logic [10:0] O_byte_count;
  logic        O_pkt_done;
  logic        O_crc_err;
  logic [15:0] O_pkt_count;

  modport master (
    output I_data, I_data_wr, I_rxactive, I_enable,
    input  O_pid, O_pid_valid, O_pid_err, O_token_addr, O_token_endp,
           O_token_valid, O_frame_num, O_sof, O_byte_count, O_pkt_done,
           O_crc_err, O_pkt_count
  );

  modport slave (
    input  I_data, I_data_wr, I_rxactive, I_enable,
    output O_pid, O_pid_valid, O_pid_err, O_token_addr, O_token_endp,
           O_token_valid, O_frame_num, O_sof, O_byte_count, O_pkt_done,
           O_crc_err, O_pkt_count
  );
endinterface

// File: rtl/pw_usb_packet_parser.sv
// USB packet parser: checks the PID byte, decodes token / SOF fields,
// counts bytes and packets and flags short or corrupt packets at end of packet.
// Optional feature macro: PW_CRC16_CHECK_EN adds a reflected CRC16 check of
// data packets (O_pid[1:0] == 2'b11); without it no CRC logic exists.
module pw_usb_packet_parser (
  input  logic                   fe_clk,
  input  logic                   reset_i,
  pw_usb_packet_parser_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, PID, BODY, DROP, DONE} state_t;

  state_t      state;
  logic        rx_prev;
  logic [1:0]  body_cnt;       // body bytes seen, saturates at 2
  logic [7:0]  byte1;
  logic [3:0]  pid;
  logic        pid_valid;
  logic        pid_err;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic        token_valid;
  logic [10:0] frame_num;
  logic        sof;
  logic [10:0] byte_count;
  logic        pkt_done;
  logic        crc_err;
  logic [15:0] pkt_count;

  logic        rx_rise;
  logic        pid_ok;
  logic [3:0]  pkt_pid;
  logic [10:0] byte_count_inc;
  logic [1:0]  body_cnt_next;
  logic        body_short;
  logic        end_err;

  // rx_prev resets high so a packet already in flight at reset release is not seen as a new one
  assign rx_rise        = bus.I_rxactive & ~rx_prev;
  assign pid_ok         = (bus.I_data[7:4] == ~bus.I_data[3:0]);
  // In PID the packet type is the byte being accepted right now, not the stored PID
  assign pkt_pid        = (state == PID) ? bus.I_data[3:0] : pid;
  assign byte_count_inc = (byte_count == 11'd2047) ? byte_count : byte_count + 11'd1;
  assign body_short     = (body_cnt_next != 2'd2);

  // Body byte count including a strobe in the current cycle
  always_comb begin
    body_cnt_next = body_cnt;
    if (state == BODY && bus.I_data_wr && body_cnt != 2'd2)
      body_cnt_next = body_cnt + 2'd1;
  end

`ifdef PW_CRC16_CHECK_EN
  logic [15:0] crc;
  logic [15:0] crc_next;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // CRC including a body byte arriving this cycle, so a final byte on the fall counts
  always_comb begin
    crc_next = crc;
    if (state == BODY && bus.I_data_wr)
      crc_next = crc16_byte(crc, bus.I_data);
  end
`endif

  // End-of-packet error: short token/SOF, plus short or bad-residue data when CRC is built
  always_comb begin
    end_err = (pkt_pid[1:0] == 2'b01) && body_short;
`ifdef PW_CRC16_CHECK_EN
    if (pkt_pid[1:0] == 2'b11)
      end_err = body_short || (crc_next != 16'hB001);
`endif
  end

  // Parser FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      body_cnt    <= 2'd0;
      byte1       <= 8'h00;
      pid         <= 4'h0;
      pid_valid   <= 1'b0;
      pid_err     <= 1'b0;
      token_addr  <= 7'h00;
      token_endp  <= 4'h0;
      token_valid <= 1'b0;
      frame_num   <= 11'h000;
      sof         <= 1'b0;
      byte_count  <= 11'h000;
      pkt_done    <= 1'b0;
      crc_err     <= 1'b0;
      pkt_count   <= 16'h0000;
`ifdef PW_CRC16_CHECK_EN
      crc         <= 16'hFFFF;
`endif
    end else begin
      rx_prev     <= bus.I_rxactive;
      pid_valid   <= 1'b0;
      pid_err     <= 1'b0;
      token_valid <= 1'b0;
      sof         <= 1'b0;
      pkt_done    <= 1'b0;
      crc_err     <= 1'b0;
      if (!bus.I_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_rise) begin
              state      <= PID;
              byte_count <= 11'h000;
              body_cnt   <= 2'd0;
`ifdef PW_CRC16_CHECK_EN
              crc        <= 16'hFFFF;
`endif
            end
          end
          PID: begin
            if (bus.I_data_wr) begin
              byte_count <= byte_count_inc;
              if (pid_ok) begin
                pid       <= bus.I_data[3:0];
                pid_valid <= 1'b1;
                if (!bus.I_rxactive) begin
                  state     <= DONE;
                  pkt_done  <= 1'b1;
                  crc_err   <= end_err;
                  pkt_count <= pkt_count + 16'd1;
                end else begin
                  state <= BODY;
                end
              end else begin
                pid_err <= 1'b1;
                state   <= bus.I_rxactive ? DROP : IDLE;
              end
            end else if (!bus.I_rxactive) begin
              state <= IDLE;
            end
          end
          BODY: begin
            if (bus.I_data_wr) begin
              byte_count <= byte_count_inc;
              body_cnt   <= body_cnt_next;
              if (body_cnt == 2'd0)
                byte1 <= bus.I_data;
              if (body_cnt == 2'd1) begin
                if (pid == 4'b0101) begin
                  frame_num <= {bus.I_data[2:0], byte1};
                  sof       <= 1'b1;
                end else if (pid[1:0] == 2'b01) begin
                  token_addr  <= byte1[6:0];
                  token_endp  <= {bus.I_data[2:0], byte1[7]};
                  token_valid <= 1'b1;
                end
              end
            end
`ifdef PW_CRC16_CHECK_EN
            crc <= crc_next;
`endif
            if (!bus.I_rxactive) begin
              state     <= DONE;
              pkt_done  <= 1'b1;
              crc_err   <= end_err;
              pkt_count <= pkt_count + 16'd1;
            end
          end
          DROP: if (!bus.I_rxactive) state <= IDLE;
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.O_pid         = pid;
  assign bus.O_pid_valid   = pid_valid;
  assign bus.O_pid_err     = pid_err;
  assign bus.O_token_addr  = token_addr;
  assign bus.O_token_endp  = token_endp;
  assign bus.O_token_valid = token_valid;
  assign bus.O_frame_num   = frame_num;
  assign bus.O_sof         = sof;
  assign bus.O_byte_count  = byte_count;
  assign bus.O_pkt_done    = pkt_done;
  assign bus.O_crc_err     = crc_err;
  assign bus.O_pkt_count   = pkt_count;
endmodule

// File: tb/tb_pw_usb_packet_parser.sv
// Scoreboard bench for pw_usb_packet_parser: a packet-level reference model
// pushes expected pulses into a queue, a monitor pops them as the DUT pulses.
// Build with +define+PW_CRC16_CHECK_EN to exercise the data-packet CRC check.
module tb_pw_usb_packet_parser;
  logic fe_clk = 1'b0;
  logic reset_i;
  always #5 fe_clk = ~fe_clk;

  pw_usb_packet_parser_if bus ();
  pw_usb_packet_parser dut (.fe_clk(fe_clk), .reset_i(reset_i), .bus(bus));

  typedef enum logic [2:0] {EV_PID, EV_PERR, EV_TOK, EV_SOF, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  pkt[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  m_pid    = 4'h0;
  logic [15:0] m_count  = 16'h0;
  logic [10:0] m_bc     = 11'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // Reflected CRC16, one bit at a time, LSB first
  function automatic logic [15:0] ref_crc();
    logic [15:0] r = 16'hFFFF;
    for (int i = 1; i < pkt.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        logic fb;
        logic [7:0] d;
        d  = pkt[i];
        fb = r[0] ^ d[k];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    end
    return r;
  endfunction

  // Packet-level model of a complete packet held in pkt
  task automatic model_packet();
    logic [7:0] b0, b1, b2;
    int body;
    logic err;
    b0 = pkt[0];
    if (b0[7:4] != ~b0[3:0]) begin
      push(EV_PERR, m_pid, 0, 0);
      return;
    end
    m_pid = b0[3:0];
    push(EV_PID, m_pid, 0, 0);
    body = pkt.size() - 1;
    if (m_pid[1:0] == 2'b01 && body >= 2) begin
      b1 = pkt[1];
      b2 = pkt[2];
      if (m_pid == 4'h5) push(EV_SOF, {21'h0, b2[2:0], b1}, 0, 0);
      else               push(EV_TOK, b1[6:0], {b2[2:0], b1[7]}, 0);
    end
    err = (m_pid[1:0] == 2'b01) && (body < 2);
`ifdef PW_CRC16_CHECK_EN
    if (m_pid[1:0] == 2'b11) err = (body < 2) || (ref_crc() != 16'hB001);
`endif
    m_count = m_count + 16'd1;
    m_bc    = (pkt.size() > 2047) ? 11'd2047 : 11'(pkt.size());
    push(EV_DONE, m_bc, err, m_count);
  endtask

  // Drive pkt as one packet; optionally drop rxactive with the last byte
  task automatic drive_pkt(input bit fall_last, input int max_gap);
    @(negedge fe_clk);
    bus.I_rxactive = 1'b1;
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge fe_clk);
      bus.I_data    = pkt[i];
      bus.I_data_wr = 1'b1;
      if (fall_last && i == pkt.size() - 1) bus.I_rxactive = 1'b0;
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(negedge fe_clk);
          bus.I_data_wr = 1'b0;
        end
      end
    end
    @(negedge fe_clk);
    bus.I_data_wr  = 1'b0;
    bus.I_rxactive = 1'b0;
    @(negedge fe_clk);
  endtask

  task automatic run_pkt(input bit fall_last, input int max_gap);
    model_packet();
    drive_pkt(fall_last, max_gap);
  endtask

  task automatic set_pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pkt.delete();
    pkt.push_back(a); pkt.push_back(b); pkt.push_back(c);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pid"},         bus.O_pid, 0);
    check({tag, "_pid_valid"},   bus.O_pid_valid, 0);
    check({tag, "_pid_err"},     bus.O_pid_err, 0);
    check({tag, "_token_addr"},  bus.O_token_addr, 0);
    check({tag, "_token_endp"},  bus.O_token_endp, 0);
    check({tag, "_token_valid"}, bus.O_token_valid, 0);
    check({tag, "_frame_num"},   bus.O_frame_num, 0);
    check({tag, "_sof"},         bus.O_sof, 0);
    check({tag, "_byte_count"},  bus.O_byte_count, 0);
    check({tag, "_pkt_done"},    bus.O_pkt_done, 0);
    check({tag, "_crc_err"},     bus.O_crc_err, 0);
    check({tag, "_pkt_count"},   bus.O_pkt_count, 0);
  endtask

  task automatic pulse_reset();
    @(negedge fe_clk);
    reset_i = 1'b1;
    @(negedge fe_clk);
    reset_i = 1'b0;
    m_pid = 4'h0; m_count = 16'h0; m_bc = 11'h0;
  endtask

  // Monitor: every output pulse must match the next expected event
  task automatic pop_cmp(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: pulse seen, none expected", k.name());
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (e.kind != k) return;
    case (k)
      EV_PID, EV_PERR: check("pid", bus.O_pid, e.a);
      EV_TOK: begin
        check("token_addr", bus.O_token_addr, e.a);
        check("token_endp", bus.O_token_endp, e.b);
      end
      EV_SOF: check("frame_num", bus.O_frame_num, e.a);
      default: begin
        check("byte_count", bus.O_byte_count, e.a);
        check("crc_err", bus.O_crc_err, e.b);
        check("pkt_count", bus.O_pkt_count, e.c);
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge fe_clk);
      if (bus.O_pid_valid)   pop_cmp(EV_PID);
      if (bus.O_pid_err)     pop_cmp(EV_PERR);
      if (bus.O_token_valid) pop_cmp(EV_TOK);
      if (bus.O_sof)         pop_cmp(EV_SOF);
      if (bus.O_pkt_done)    pop_cmp(EV_DONE);
    end
  end

  logic [7:0] pid_tbl[12] = '{8'hE1, 8'h69, 8'hA5, 8'h2D, 8'hC3, 8'h4B,
                              8'h87, 8'h0F, 8'hD2, 8'h5A, 8'h1E, 8'h96};

  initial begin
    logic [15:0] saved_count;
    reset_i        = 1'b1;
    bus.I_data     = 8'h00;
    bus.I_data_wr  = 1'b0;
    bus.I_rxactive = 1'b0;
    bus.I_enable   = 1'b1;
    repeat (3) @(negedge fe_clk);
    check_all_zero("reset");
    reset_i = 1'b0;

    // SOF frame 0x53A
    set_pkt3(8'hA5, 8'h3A, 8'h05);
    run_pkt(1'b0, 0);
    check("sof_frame_num", bus.O_frame_num, 11'h53A);
    check("sof_pkt_count", bus.O_pkt_count, 16'd1);

    // IN token addr 2 endp 3
    set_pkt3(8'h69, 8'h82, 8'h01);
    run_pkt(1'b1, 0);
    check("in_token_addr", bus.O_token_addr, 7'h02);
    check("in_token_endp", bus.O_token_endp, 4'h3);

    // Bad PID: dropped, packet count unchanged
    saved_count = m_count;
    set_pkt3(8'h00, 8'h12, 8'h34);
    run_pkt(1'b0, 1);
    check("badpid_pkt_count", bus.O_pkt_count, saved_count);

    // DATA0 with good and bad CRC field
    set_pkt3(8'hC3, 8'h00, 8'h00);
    run_pkt(1'b0, 0);
    set_pkt3(8'hC3, 8'h00, 8'h01);
    run_pkt(1'b1, 0);

    // Strobes while idle are ignored
    repeat (4) begin
      @(negedge fe_clk);
      bus.I_data    = 8'($urandom);
      bus.I_data_wr = 1'b1;
    end
    @(negedge fe_clk);
    bus.I_data_wr = 1'b0;
    check("idle_byte_count", bus.O_byte_count, m_bc);

    // Enable dropped mid-packet: PID accepted, no end of packet, outputs hold
    push(EV_PID, 4'hD, 0, 0);
    m_pid = 4'hD;
    @(negedge fe_clk); bus.I_rxactive = 1'b1;
    @(negedge fe_clk); bus.I_data = 8'h2D; bus.I_data_wr = 1'b1;
    @(negedge fe_clk); bus.I_data = 8'h11;
    @(negedge fe_clk); bus.I_data_wr = 1'b0; bus.I_enable = 1'b0;
    repeat (2) @(negedge fe_clk);
    bus.I_rxactive = 1'b0;
    @(negedge fe_clk); bus.I_enable = 1'b1;
    @(negedge fe_clk);
    check("enable_byte_count", bus.O_byte_count, 11'd2);
    check("enable_queue_empty", exp_q.size(), 0);

    // Randomised packets
    for (int n = 0; n < 300; n++) begin
      int len;
      pkt.delete();
      if ($urandom_range(7, 0) == 0) pkt.push_back(8'($urandom));
      else                           pkt.push_back(pid_tbl[$urandom_range(11, 0)]);
      len = $urandom_range(6, 0);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      run_pkt(1'($urandom), 2);
    end
    check("random_queue_empty", exp_q.size(), 0);

    // Reset after byte 2 of a 10-byte DATA0 packet
    push(EV_PID, 4'h3, 0, 0);
    @(negedge fe_clk); bus.I_rxactive = 1'b1;
    @(negedge fe_clk); bus.I_data = 8'hC3; bus.I_data_wr = 1'b1;
    @(negedge fe_clk); bus.I_data = 8'h5A;
    @(negedge fe_clk); bus.I_data_wr = 1'b0; reset_i = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge fe_clk); reset_i = 1'b0;
    m_pid = 4'h0; m_count = 16'h0; m_bc = 11'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge fe_clk); bus.I_data = 8'($urandom); bus.I_data_wr = 1'b1;
    end
    @(negedge fe_clk); bus.I_data_wr = 1'b0; bus.I_rxactive = 1'b0;
    @(negedge fe_clk);
    check("after_reset_ignored_bc", bus.O_byte_count, 0);
    check("after_reset_queue_empty", exp_q.size(), 0);
    set_pkt3(8'hE1, 8'h85, 8'h04);
    run_pkt(1'b0, 0);
    check("after_reset_pkt_count", bus.O_pkt_count, 16'd1);

    // Long packet: byte count saturates
    pkt.delete();
    pkt.push_back(8'h4B);
    for (int i = 0; i < 2099; i++) pkt.push_back(8'($urandom));
    run_pkt(1'b0, 0);
    check("long_byte_count", bus.O_byte_count, 11'd2047);

    // Packet counter wrap after 65536 SOF packets from reset
    pulse_reset();
    for (int n = 0; n < 65536; n++) begin
      set_pkt3(8'hA5, 8'(n), 8'(n >> 8));
      run_pkt(1'b1, 0);
    end
    check("wrap_pkt_count", bus.O_pkt_count, 16'h0000);

    repeat (5) @(negedge fe_clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
